// File: rtl/oam_dma.sv
// Sprite DMA: a $4014 write halts the CPU and copies one 256-byte page to OAMDATA,
// keeping get/put parity so every read lands on a get cycle.
module oam_dma #(
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
    parameter int unsigned TRANSFER_LEN = 256
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cs_n,
    input  logic        i_rw,
    input  logic [7:0]  i_data,
    input  logic        i_cpu_rw,
    output logic        o_rdy,
    output logic        o_bus_en,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data,
    input  logic [7:0]  i_mem_data,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_e;

    localparam logic [7:0] LAST_INDEX = 8'(TRANSFER_LEN - 1);

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] byte_q, byte_d;
    logic       r_put_q;

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            page_q  <= '0;
            index_q <= '0;
            byte_q  <= '0;
            r_put_q <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
            byte_q  <= byte_d;
            r_put_q <= ~r_put_q;
        end
    end

    // Outputs decode from state and registers only, never from i_mem_data.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        index_d   = index_q;
        byte_d    = byte_q;
        o_rdy     = 1'b0;
        o_bus_en  = 1'b0;
        o_address = '0;
        o_rw      = 1'b1;
        o_data    = '0;
        o_busy    = 1'b1;
        case (state_q)
            IDLE: begin
                o_rdy  = 1'b1;
                o_busy = 1'b0;
                if (!i_cs_n && !i_rw) begin
                    page_d  = i_data;
                    index_d = '0;
                    state_d = HALT;
                end
            end
            HALT: begin
                // A CPU still writing ignores RDY, so wait until it reaches a read.
                if (i_cpu_rw) begin
                    state_d = r_put_q ? READ : ALIGN;
                end
            end
            ALIGN: begin
                state_d = READ;
            end
            READ: begin
                o_bus_en  = 1'b1;
                o_address = {page_q, index_q};
                byte_d    = i_mem_data;
                state_d   = WRITE;
            end
            WRITE: begin
                o_bus_en  = 1'b1;
                o_rw      = 1'b0;
                o_address = OAMDATA_ADDR;
                o_data    = byte_q;
                if (index_q == LAST_INDEX) begin
                    state_d = IDLE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: observed bus traffic is scored against the
// transfer rules (addresses, data order, parity, RDY-low duration).
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic        rw;
    logic [7:0]  data;
    logic        cpu_rw;
    logic        rdy;
    logic        bus_en;
    logic [15:0] addr;
    logic        dma_rw;
    logic [7:0]  dma_data;
    logic [7:0]  mem_data;
    logic        busy;

    logic [7:0]  mem [0:65535];

    typedef struct {
        logic        rw;
        logic [15:0] a;
        logic [7:0]  d;
        int unsigned c;
    } acc_t;

    acc_t        q[$];
    int unsigned cyc;
    int unsigned low_cnt;
    int unsigned idle_bad;
    int          n_vec = 0;
    int          n_err = 0;

    oam_dma #(
        .OAMDATA_ADDR (16'h2004),
        .TRANSFER_LEN (256)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_cs_n     (cs_n),
        .i_rw       (rw),
        .i_data     (data),
        .i_cpu_rw   (cpu_rw),
        .o_rdy      (rdy),
        .o_bus_en   (bus_en),
        .o_address  (addr),
        .o_rw       (dma_rw),
        .o_data     (dma_data),
        .i_mem_data (mem_data),
        .o_busy     (busy)
    );

    assign mem_data = mem[addr];

    always #5 clk = ~clk;

    // Cycle number since reset; its parity is the get/put phase (even = get).
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        acc_t acc;
        @(negedge clk);
        @(posedge clk);
        if (rdy !== 1'b1) low_cnt++;
        if (busy === rdy) idle_bad++;
        if (bus_en === 1'b1) begin
            acc.rw = dma_rw;
            acc.a  = addr;
            acc.d  = dma_data;
            acc.c  = cyc;
            q.push_back(acc);
        end else if (addr !== 16'h0 || dma_rw !== 1'b1 || dma_data !== 8'h0) begin
            idle_bad++;
        end
    endtask

    task automatic run_xfer(input logic [7:0] page, input bit want_align, input int unsigned hold,
                            input bit intrude, input int abort_at, input bit pattern);
        int unsigned halt_cyc;
        int unsigned guard;
        bit          align;
        for (int i = 0; i < 256; i++)
            mem[{page, 8'(i)}] = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
        while (((cyc % 2) == ((hold + 1) % 2)) != want_align) step();
        q.delete();
        low_cnt  = 0;
        idle_bad = 0;
        cs_n = 1'b0; rw = 1'b0; data = page;
        step();
        cs_n = 1'b1; rw = 1'b1; data = 8'($urandom);
        halt_cyc = cyc;
        check("trig_rdy", 32'(rdy), 32'd0);
        check("trig_busy", 32'(busy), 32'd1);
        check("halt_bus", 32'(bus_en), 32'd0);
        for (int unsigned i = 0; i < hold; i++) begin
            cpu_rw = 1'b0;
            step();
            check("hold_bus", 32'(bus_en), 32'd0);
        end
        cpu_rw = 1'b1;
        align = ((halt_cyc + hold) % 2) == 0;
        guard = 0;
        while (rdy !== 1'b1 && guard < 700) begin
            if (intrude && guard == 40) begin
                cs_n = 1'b0; rw = 1'b0; data = 8'h07;
            end else begin
                cs_n = 1'b1; rw = 1'b1;
            end
            step();
            guard++;
            if (abort_at >= 0 && q.size() == 2 * abort_at + 1) begin
                rst_n = 1'b0;
                #1;
                check("abort_rdy", 32'(rdy), 32'd1);
                check("abort_bus", 32'(bus_en), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_addr", 32'(addr), 32'd0);
                repeat (2) @(posedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        cs_n = 1'b1; rw = 1'b1;
        check("done_in_time", 32'(guard < 700), 32'd1);
        check("rdy_low", low_cnt, 513 + hold + 32'(align));
        check("n_access", q.size(), 32'd512);
        for (int i = 0; i < 256 && 2 * i + 1 < q.size(); i++) begin
            check("rd_rw", 32'(q[2*i].rw), 32'd1);
            check("rd_addr", 32'(q[2*i].a), 32'({page, 8'(i)}));
            check("rd_get", q[2*i].c % 2, 32'd0);
            check("wr_rw", 32'(q[2*i+1].rw), 32'd0);
            check("wr_addr", 32'(q[2*i+1].a), 32'h2004);
            check("wr_data", 32'(q[2*i+1].d), 32'(mem[{page, 8'(i)}]));
        end
        if (q.size() > 0) check("first_rd_lat", q[0].c - halt_cyc, 1 + hold + 32'(align));
        if (pattern && q.size() == 512) begin
            check("ff_first", 32'(q[1].d), 32'hA5);
            check("ff_last", 32'(q[511].d), 32'h5A);
            check("ff_last_rd", 32'(q[510].a), 32'hFFFF);
        end
        check("idle_outputs", idle_bad, 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_bus", 32'(bus_en), 32'd0);
        repeat (4) step();
        check("no_extra_access", q.size(), 32'd512);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0; cs_n = 1'b1; rw = 1'b1; data = 8'h00; cpu_rw = 1'b1;
        repeat (3) @(posedge clk);
        check("rst_rdy", 32'(rdy), 32'd1);
        check("rst_bus", 32'(bus_en), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_rw", 32'(dma_rw), 32'd1);
        check("rst_data", 32'(dma_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        run_xfer(8'h02, 1'b0, 0, 1'b0, -1, 1'b0);
        run_xfer(8'h02, 1'b1, 0, 1'b0, -1, 1'b0);
        run_xfer(8'h03, 1'b0, 3, 1'b0, -1, 1'b0);
        run_xfer(8'h04, 1'b1, 3, 1'b0, -1, 1'b0);
        run_xfer(8'hFF, 1'b0, 0, 1'b0, -1, 1'b1);
        run_xfer(8'h05, 1'b0, 0, 1'b0, 100, 1'b0);
        run_xfer(8'h06, 1'b1, 1, 1'b0, -1, 1'b0);
        run_xfer(8'h20, 1'b0, 0, 1'b1, -1, 1'b0);
        for (int k = 0; k < 4; k++)
            run_xfer(8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom), -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side sprite DMA engine, upstream of the PPU.
- A CPU write to $4014 latches a source page, halts the CPU via RDY, then copies 256 bytes from CPU address space ${page}00–${page}FF to the PPU OAMDATA port ($2004).
- Sits between the CPU bus decoder and the PPU register interface; it drives the shared CPU address/data bus while it owns it.
- It keeps its own get/put cycle parity so reads always land on get cycles, as on the 2A03.

Parameters:
- OAMDATA_ADDR, 16'h2004, destination address of every DMA write.
- TRANSFER_LEN, 256, bytes per transfer. Fixed; index counter is 8 bits.

Ports:
- i_clk  in  1  system clock; all state updates on its falling edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_cs_n  in  1  chip select, low when the CPU addresses $4014.
- i_rw  in  1  CPU read/~write for the $4014 access.
- i_data  in  8  CPU write data (source page number).
- i_cpu_rw  in  1  CPU's current-cycle R/~W, used to detect that the CPU has stalled on a read.
- o_rdy  out  1  to CPU RDY; 0 halts the CPU.
- o_bus_en  out  1  1 when the DMA drives the CPU address/data/rw bus.
- o_address  out  16  DMA bus address (0 when o_bus_en=0).
- o_rw  out  1  DMA bus read/~write (1 when idle).
- o_data  out  8  DMA write data (0 unless a WRITE cycle).
- i_mem_data  in  8  CPU-bus read data during DMA reads.
- o_busy  out  1  1 from trigger until the last write completes.

Behaviour:
Reset values (async, on i_reset_n=0):
- Registers: state=IDLE, page=0, index=0, byte latch=0, r_put=0.
- Outputs: o_rdy=1, o_bus_en=0, o_address=0, o_rw=1, o_data=0, o_busy=0.
- Reset mid-transfer aborts immediately and releases the bus; no partial-state retention.

Parity:
- r_put toggles every clock from reset. r_put=0 is a get (read) cycle; r_put=1 is a put (write) cycle.

Trigger:
- In IDLE, an edge with i_cs_n=0 and i_rw=0 latches page=i_data, sets index=0, and enters HALT.
- o_rdy=0 and o_busy=1 from the next cycle.
- $4014 writes in any non-IDLE state are ignored.

States:
- IDLE: o_bus_en=0, o_rdy=1.
- HALT: o_rdy=0, o_bus_en=0.
  - If i_cpu_rw=0 (CPU still writing; RDY not honoured), stay in HALT.
  - Else if r_put=1 (next cycle is get), go to READ.
  - Else go to ALIGN.
- ALIGN: one dummy cycle, o_bus_en=0, then READ. Guaranteed on a get cycle.
- READ: o_bus_en=1, o_rw=1, o_address={page,index}. At the edge, latch i_mem_data, then go to WRITE.
- WRITE: o_bus_en=1, o_rw=0, o_address=OAMDATA_ADDR, o_data=latched byte. At the edge:
  - if index=255, go to IDLE (o_rdy=1, o_busy=0 next cycle);
  - otherwise index+1, then READ.

Latency:
- Trigger edge to o_rdy re-asserted: 1 HALT + 0/1 ALIGN + 512 cycles = 513 or 514 cycles, plus any extra HALT cycles spent waiting on CPU writes.

Boundary behaviour:
- Index wrap: after byte 255, index does not roll into a 257th access.
- Page $FF reads $FF00–$FFFF. Page $20 is legal (reads PPU registers) and is not special-cased.
- All outputs are registered or decoded from state only; none depends combinationally on i_mem_data.

Test Plan:
- Reset with r_put settled, write $02 to $4014 with i_cpu_rw=1 afterwards, trigger landing so HALT sees r_put=1 -> no ALIGN. First READ at $0200, first WRITE at $2004; o_rdy low exactly 513 cycles; 256 writes carry mem[$0200..$02FF] in order.
- Same as the first case but trigger shifted one cycle (HALT sees r_put=0) -> exactly one ALIGN cycle with o_bus_en=0; o_rdy low 514 cycles; every READ on r_put=0.
- Hold i_cpu_rw=0 for 3 cycles after trigger -> stays in HALT 3 extra cycles, o_bus_en=0 throughout; transfer then completes normally (516 or 517 cycles low).
- Page $FF with mem[$FFxx]=xx^$A5 -> WRITE data sequence $A5,$A4,…,$5A; last READ address $FFFF; no access at $0000 afterwards.
- Assert i_reset_n=0 at transfer byte 100 -> same cycle: o_rdy=1, o_bus_en=0, o_busy=0, o_address=0. New trigger after reset restarts from index 0.
- Write $4014 again during a transfer (page $07) -> ignored; addresses keep the original page, and the total count stays 256.
